// File: rtl/conf_responder.sv
`default_nettype none
// ============================================================================
//  Module   : conf_responder
//  Brief    : Memory-mapped configuration responder. Provides scratch
//             registers, LED / seven-segment number registers, a synchronized
//             switch read-back port and an optional free-running timer with a
//             sticky compare flag.
//  Options  : define CONF_TIMER_EN to build TIMER, TIMER_CMP and timer_irq;
//             without it those addresses read as zero and timer_irq is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module conf_responder #(
    parameter int SWITCH_W    = 8,
    parameter int SCRATCH_NUM = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                conf_en,
    input  logic [3:0]          conf_wen,
    input  logic [31:0]         conf_addr,
    input  logic [31:0]         conf_wdata,
    output logic [31:0]         conf_rdata,
    input  logic [SWITCH_W-1:0] switch,
    output logic [15:0]         led,
    output logic [31:0]         num_data,
    output logic                timer_irq
);

    // ------------------------------------------------------------------
    // Register map, expressed as word addresses (byte address >> 2)
    // ------------------------------------------------------------------
    localparam logic [10:0] c_cr_block   = 11'h400;   // 0x8000..0x801C
    localparam logic [13:0] c_word_timer = 14'h3800;  // 0xE000
    localparam logic [13:0] c_word_cmp   = 14'h3801;  // 0xE004
    localparam logic [13:0] c_word_led   = 14'h3C00;  // 0xF000
    localparam logic [13:0] c_word_num   = 14'h3C08;  // 0xF020
    localparam logic [13:0] c_word_sw    = 14'h3C0C;  // 0xF030
    localparam logic [3:0]  c_cr_count   = 4'(SCRATCH_NUM);

    // Replace the byte lanes selected by 'lanes' with the new data.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [13:0] w_word;
    logic [2:0]  w_cr_idx;
    logic        w_wr;
    logic        w_rd;
    logic        w_cr_hit;
    logic        w_sel_timer;
    logic        w_sel_cmp;
    logic        w_sel_led;
    logic        w_sel_num;
    logic        w_unused_addr;

    assign w_word      = conf_addr[15:2];
    assign w_cr_idx    = w_word[2:0];
    assign w_wr        = conf_en && (conf_wen != 4'b0000);
    assign w_rd        = conf_en && (conf_wen == 4'b0000);
    // Only as many scratch slots as were configured respond; the rest of
    // the 8-word window is unmapped.
    assign w_cr_hit    = (w_word[13:3] == c_cr_block) && ({1'b0, w_cr_idx} < c_cr_count);
    assign w_sel_timer = (w_word == c_word_timer);
    assign w_sel_cmp   = (w_word == c_word_cmp);
    assign w_sel_led   = (w_word == c_word_led);
    assign w_sel_num   = (w_word == c_word_num);
    // Address bits outside [15:2] are deliberately ignored.
    assign w_unused_addr = &{1'b0, conf_addr[31:16], conf_addr[1:0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]         r_scratch [SCRATCH_NUM];
    logic [31:0]         r_led;
    logic [31:0]         r_num;
    logic [31:0]         r_rdata;
    logic [SWITCH_W-1:0] r_sw_meta;
    logic [SWITCH_W-1:0] r_sw_sync;
    logic [31:0]         w_sw_ext;
    logic [31:0]         w_timer_val;
    logic [31:0]         w_cmp_val;
    logic [31:0]         w_rd_val;

    assign w_sw_ext = 32'(r_sw_sync);

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Scratch registers: byte-lane writes to the addressed slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SCRATCH_NUM; i++) begin
                r_scratch[i] <= '0;
            end
        end else if (w_wr && w_cr_hit) begin
            for (int i = 0; i < SCRATCH_NUM; i++) begin
                if (w_cr_idx == 3'(i)) begin
                    r_scratch[i] <= byte_merge(r_scratch[i], conf_wdata, conf_wen);
                end
            end
        end
    end

    // LED and seven-segment number registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led <= '0;
            r_num <= '0;
        end else if (w_wr) begin
            if (w_sel_led) begin
                r_led <= byte_merge(r_led, conf_wdata, conf_wen);
            end
            if (w_sel_num) begin
                r_num <= byte_merge(r_num, conf_wdata, conf_wen);
            end
        end
    end

`ifdef CONF_TIMER_EN
    logic [31:0] r_timer;
    logic [31:0] r_timer_cmp;
    logic        r_timer_irq;
    logic        w_timer_match;

    assign w_timer_match = (r_timer == r_timer_cmp) && (r_timer_cmp != 32'd0);

    // Free-running timer; a software write replaces the increment for that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (w_wr && w_sel_timer) begin
            r_timer <= byte_merge(r_timer, conf_wdata, conf_wen);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Timer compare value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer_cmp <= '0;
        end else if (w_wr && w_sel_cmp) begin
            r_timer_cmp <= byte_merge(r_timer_cmp, conf_wdata, conf_wen);
        end
    end

    // Sticky compare flag; a compare write wins over a same-cycle match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer_irq <= 1'b0;
        end else if (w_wr && w_sel_cmp) begin
            r_timer_irq <= 1'b0;
        end else if (w_timer_match) begin
            r_timer_irq <= 1'b1;
        end
    end

    assign w_timer_val = r_timer;
    assign w_cmp_val   = r_timer_cmp;
    assign timer_irq   = r_timer_irq;
`else
    assign w_timer_val = 32'd0;
    assign w_cmp_val   = 32'd0;
    assign timer_irq   = 1'b0;
`endif

    // Read multiplexer over the current register values.
    always_comb begin
        w_rd_val = 32'd0;
        if (w_cr_hit) begin
            for (int i = 0; i < SCRATCH_NUM; i++) begin
                if (w_cr_idx == 3'(i)) begin
                    w_rd_val = r_scratch[i];
                end
            end
        end else begin
            case (w_word)
                c_word_timer: w_rd_val = w_timer_val;
                c_word_cmp:   w_rd_val = w_cmp_val;
                c_word_led:   w_rd_val = r_led;
                c_word_num:   w_rd_val = r_num;
                c_word_sw:    w_rd_val = w_sw_ext;
                default:      w_rd_val = 32'd0;
            endcase
        end
    end

    // Read data register: loads only on a read request, holds otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_val;
        end
    end

    assign conf_rdata = r_rdata;
    assign led        = r_led[15:0];
    assign num_data   = r_num;

endmodule
`default_nettype wire

// File: doc/conf_responder.md
CONF_RESPONDER -- requirements
Module: conf_responder

Interface
REQ-001 SHALL have parameter SWITCH_W, default 8: width of switch input.
REQ-002 SHALL have parameter SCRATCH_NUM, default 8: number of 32-bit scratch registers (1..8).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port conf_en  input  1: access request this cycle.
REQ-006 SHALL have port conf_wen  input  4: byte write enables; 0 means read.
REQ-007 SHALL have port conf_addr  input  32: byte address; only bits [15:2] decoded.
REQ-008 SHALL have port conf_wdata  input  32: write data.
REQ-009 SHALL have port conf_rdata  output  32: registered read data.
REQ-010 SHALL have port switch  input  SWITCH_W: asynchronous board switches.
REQ-011 SHALL have port led  output  16: LED register value.
REQ-012 SHALL have port num_data  output  32: seven-segment number register value.
REQ-013 SHALL have port timer_irq  output  1: sticky timer-compare flag.

Function
REQ-014 SHALL decode conf_addr[15:0]: 0x8000+4*i scratch CRi (i<SCRATCH_NUM); 0xE000 TIMER; 0xE004 TIMER_CMP; 0xF000 LED; 0xF020 NUM; 0xF030 SWITCH (read-only); all else unmapped.
REQ-015 SHALL, on conf_en=1 and conf_wen=0, drive conf_rdata with the addressed register value on the following cycle (latency exactly 1).
REQ-016 SHALL hold conf_rdata unchanged in any cycle with conf_en=0 or conf_wen!=0.
REQ-017 SHALL, on conf_en=1 and conf_wen!=0, update only byte lanes k with conf_wen[k]=1 of the addressed writable register at the clock edge.
REQ-018 SHALL return new value on a read issued the cycle after a write to the same register.
REQ-019 SHALL return 0 for unmapped reads and ignore unmapped writes and writes to SWITCH.
REQ-020 SHALL pass switch through a two-flop synchronizer; SWITCH read returns the synchronized value zero-extended.
REQ-021 SHALL increment TIMER by 1 every cycle, wrapping 0xFFFFFFFF to 0x00000000.
REQ-022 SHALL, when TIMER is written, load the byte-merged value instead of incrementing that cycle; increment resumes next cycle.
REQ-023 SHALL set timer_irq the cycle after TIMER equals TIMER_CMP with TIMER_CMP nonzero.
REQ-024 SHALL clear timer_irq on any write to TIMER_CMP; a simultaneous match and TIMER_CMP write SHALL leave timer_irq cleared.
REQ-025 SHALL keep timer_irq set until cleared, regardless of further matches or TIMER wrap.
REQ-026 SHALL drive led and num_data directly from LED[15:0] and NUM registers.

Reset
REQ-027 SHALL, while resetn=0, force conf_rdata=0, all scratch=0, TIMER=0, TIMER_CMP=0, LED=0x0000, NUM=0, timer_irq=0, synchronizer flops=0.
REQ-028 SHALL abandon any access in flight at reset assertion; first access after resetn deassertion behaves per REQ-015/017.

Configuration
REQ-029 SHALL, with macro CONF_TIMER_EN defined, implement TIMER, TIMER_CMP and timer_irq per REQ-021..025.
REQ-030 SHALL, without CONF_TIMER_EN, read 0 at 0xE000/0xE004, ignore writes there, and tie timer_irq to 0.

Verification
REQ-031 SHALL cover: write 0x12345678 wen=4'hF to 0x8004, read 0x8004 next cycle -> conf_rdata=0x12345678 exactly one cycle after read request.
REQ-032 SHALL cover: CR0=0xFFFFFFFF, write 0x000000AA wen=4'b0001 -> read 0xFFFFFFAA; write wen=4'b1000 data 0x11000000 -> read 0x11FFFFAA.
REQ-033 SHALL cover: switch=8'h5A changed asynchronously -> SWITCH read reflects 0x0000005A no earlier than 2 cycles after change; read 0x1234 -> 0; conf_en=0 cycles -> conf_rdata held.
REQ-034 SHALL cover (CONF_TIMER_EN): write TIMER=0xFFFFFFFE -> reads 0xFFFFFFFF then 0x00000000 on consecutive cycles; TIMER_CMP=0x10 -> timer_irq=1 one cycle after TIMER==0x10, stays 1 after wrap, clears on TIMER_CMP write.
REQ-035 SHALL cover: assert resetn=0 mid-write to LED with led=0xBEEF -> led=0x0000, conf_rdata=0, timer_irq=0 immediately without clock edge.
REQ-036 SHALL cover (no CONF_TIMER_EN): write 0x55 to 0xE000, read back -> 0; timer_irq constant 0.
